rs232_tx: RTL and testbench

UART transmitter, the transmit-side counterpart of Rs232_rx. It serialises one parallel byte into an 8N1 frame on the tx line: start bit, data bits LSB first, stop bit. It runs at a fixed baud rate derived from the system clock. It sits between the user logic that produces bytes and the board RS-232 TX pin, and reports busy and completion status back to the user logic.

---
 rtl/rs232_tx.sv | 119 +++++++++++
 tb/tb_rs232_tx.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_tx.sv
// UART 8N1 transmitter (8E1/8O1 when RS232_TX_PARITY_EN is defined); tx falls 1 clk after acceptance.
// Latency: start bit on tx 1 clk after pi_flag; every bit lasts BAUD_CNT_MAX clks; tx_done pulses at frame end.
// Backpressure: none; pi_flag while busy is dropped, so the producer must watch busy/tx_done.
module rs232_tx #(
    parameter int UART_BPS   = 9600,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int CNT_W        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT_MAX - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RS232_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             bit_end;
`ifdef RS232_TX_PARITY_EN
    logic             parity_bit;
`endif

    assign bit_end = (state != IDLE) && (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
`ifdef RS232_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE)
                baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (pi_flag && !busy) begin
                        shreg    <= pi_data;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= START;
`ifdef RS232_TX_PARITY_EN
                        // Parity is fixed at acceptance since the shift register is consumed bit by bit.
                        parity_bit <= (^pi_data) ^ (PARITY_ODD != 0);
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == 3'd7) begin
`ifdef RS232_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef RS232_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        busy    <= 1'b0;
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_tx.sv
// Bench for rs232_tx: a line monitor decodes frames from tx and checks them against a scoreboard of sent bytes.
module tb_rs232_tx;

    localparam int UART_BPS   = 10;
    localparam int CLK_FREQ   = 160;
    localparam int PARITY_ODD = 0;
    localparam int N          = CLK_FREQ / UART_BPS;
`ifdef RS232_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * N;

    logic       clk;
    logic       rst;
    logic [7:0] pi_data;
    logic       pi_flag;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int total;
    int bad;
    int rx_cnt;
    logic [7:0] sb[$];

    rs232_tx #(
        .UART_BPS  (UART_BPS),
        .CLK_FREQ  (CLK_FREQ),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pi_data(pi_data),
        .pi_flag(pi_flag),
        .tx     (tx),
        .busy   (busy),
        .tx_done(tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Line monitor: detect a falling edge on an idle line, sample each bit at its middle.
    initial begin : monitor
        logic       prev_tx;
        logic       aborted;
        logic [10:0] bits;
        logic [7:0]  exp_b;
        logic [7:0]  got_b;
        prev_tx = 1'b1;
        bits    = '0;
        forever begin
            @(negedge clk);
            if (!rst && prev_tx === 1'b1 && tx === 1'b0) begin
                aborted = 1'b0;
                for (int cyc = 1; cyc <= (NBITS - 1) * N + N / 2; cyc++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (cyc >= N / 2 && ((cyc - N / 2) % N) == 0)
                        bits[(cyc - N / 2) / N] = tx;
                end
                if (!aborted) begin
                    rx_cnt++;
                    got_b = bits[8:1];
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_frame: got byte %02h, no byte pending", got_b);
                    end else begin
                        exp_b = sb.pop_front();
                        if (got_b !== exp_b) begin
                            bad++;
                            $display("FAIL frame_data: got %02h expected %02h", got_b, exp_b);
                        end
                        total++;
                        if (bits[0] !== 1'b0 || bits[NBITS-1] !== 1'b1) begin
                            bad++;
                            $display("FAIL frame_framing: start=%b stop=%b expected start=0 stop=1",
                                     bits[0], bits[NBITS-1]);
                        end
`ifdef RS232_TX_PARITY_EN
                        total++;
                        if (bits[9] !== ((^exp_b) ^ (PARITY_ODD != 0))) begin
                            bad++;
                            $display("FAIL frame_parity: got %b expected %b", bits[9],
                                     (^exp_b) ^ (PARITY_ODD != 0));
                        end
`endif
                    end
                end
            end
            prev_tx = tx;
        end
    end

    task automatic send(input logic [7:0] d, input bit push);
        @(negedge clk);
        pi_data = d;
        pi_flag = 1'b1;
        if (push) sb.push_back(d);
        @(posedge clk);
        #1;
        pi_flag = 1'b0;
    endtask

    // Called #1 after the acceptance edge; returns clk edges until tx_done is seen (bounded).
    task automatic wait_done(output int c);
        c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (tx_done !== 1'b1 && c < FRAME + 20);
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        pi_flag = 1'b0;
        pi_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: tx=%b busy=%b tx_done=%b expected 1 0 0", tx, busy, tx_done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: tx=%b busy=%b expected 1 0", tx, busy);
        end
    endtask

    task automatic test_basic;
        int  c;
        int  rx0;
        bit  busy_ok;
        rx0 = rx_cnt;
        send(8'h55, 1'b1);
        pi_data = 8'hAA;
        total++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_accept: tx=%b busy=%b expected 0 1", tx, busy);
        end
        busy_ok = 1'b1;
        c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
            if (tx_done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
        end while (tx_done !== 1'b1 && c < FRAME + 20);
        total++;
        if (tx_done !== 1'b1 || c != FRAME) begin
            bad++;
            $display("FAIL basic_frame_len: tx_done after %0d clks expected %0d", c, FRAME);
        end
        total++;
        if (!busy_ok) begin
            bad++;
            $display("FAIL basic_busy_hold: busy dropped during frame, expected high throughout");
        end
        total++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            bad++;
            $display("FAIL basic_end_state: busy=%b tx=%b expected 0 1", busy, tx);
        end
        @(posedge clk);
        #1;
        total++;
        if (tx_done !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_pulse: tx_done=%b one clk later expected 0", tx_done);
        end
        total++;
        if (rx_cnt != rx0 + 1) begin
            bad++;
            $display("FAIL basic_rx_count: %0d frames expected %0d", rx_cnt - rx0, 1);
        end
    endtask

    task automatic test_back_to_back;
        int c;
        int rx0;
        rx0 = rx_cnt;
        send(8'h00, 1'b1);
        wait_done(c);
        total++;
        if (tx_done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done_cycle: tx_done=%b busy=%b tx=%b expected 1 0 1", tx_done, busy, tx);
        end
        pi_data = 8'hFF;
        pi_flag = 1'b1;
        sb.push_back(8'hFF);
        @(posedge clk);
        #1;
        pi_flag = 1'b0;
        total++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept: tx=%b busy=%b expected 0 1", tx, busy);
        end
        wait_done(c);
        total++;
        if (tx_done !== 1'b1 || c != FRAME) begin
            bad++;
            $display("FAIL b2b_frame_len: tx_done after %0d clks expected %0d", c, FRAME);
        end
        total++;
        if (rx_cnt != rx0 + 2) begin
            bad++;
            $display("FAIL b2b_rx_count: %0d frames expected %0d", rx_cnt - rx0, 2);
        end
    endtask

    task automatic test_ignore_busy;
        int rx0;
        int dones;
        rx0 = rx_cnt;
        send(8'h3C, 1'b1);
        repeat (3 * N + 5) @(posedge clk);
        #1;
        pi_data = 8'hA3;
        pi_flag = 1'b1;
        @(posedge clk);
        #1;
        pi_flag = 1'b0;
        dones = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk);
            #1;
            if (tx_done === 1'b1) dones++;
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL ignore_done_count: %0d tx_done pulses expected 1", dones);
        end
        total++;
        if (rx_cnt != rx0 + 1) begin
            bad++;
            $display("FAIL ignore_rx_count: %0d frames expected 1", rx_cnt - rx0);
        end
    endtask

    task automatic test_reset_mid;
        int  c;
        int  rx0;
        bit  no_done;
        rx0 = rx_cnt;
        send(8'hF0, 1'b0);
        repeat (61) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_async: tx=%b busy=%b tx_done=%b expected 1 0 0", tx, busy, tx_done);
        end
        no_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (tx_done !== 1'b0 || tx !== 1'b1) no_done = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            @(posedge clk);
            #1;
            if (tx_done !== 1'b0 || tx !== 1'b1) no_done = 1'b0;
        end
        total++;
        if (!no_done || rx_cnt != rx0) begin
            bad++;
            $display("FAIL midreset_quiet: done/line activity seen=%b frames=%0d expected 0 0",
                     !no_done, rx_cnt - rx0);
        end
        send(8'h0F, 1'b1);
        wait_done(c);
        total++;
        if (tx_done !== 1'b1 || c != FRAME || rx_cnt != rx0 + 1) begin
            bad++;
            $display("FAIL midreset_recover: len=%0d frames=%0d expected %0d 1", c, rx_cnt - rx0, FRAME);
        end
    endtask

    task automatic test_back_to_back_burst;
        int c;
        int rx0;
        int good_len;
        rx0 = rx_cnt;
        good_len = 0;
        send(8'd0, 1'b1);
        for (int i = 1; i < 8; i++) begin
            wait_done(c);
            if (tx_done === 1'b1 && c == FRAME) good_len++;
            pi_data = 8'(i);
            pi_flag = 1'b1;
            sb.push_back(8'(i));
            @(posedge clk);
            #1;
            pi_flag = 1'b0;
        end
        wait_done(c);
        if (tx_done === 1'b1 && c == FRAME) good_len++;
        total++;
        if (good_len != 8) begin
            bad++;
            $display("FAIL burst_frames: %0d correctly timed frames expected 8", good_len);
        end
        total++;
        if (rx_cnt != rx0 + 8) begin
            bad++;
            $display("FAIL burst_rx_count: %0d frames expected 8", rx_cnt - rx0);
        end
    endtask

`ifdef RS232_TX_PARITY_EN
    task automatic test_parity;
        int c;
        send(8'h07, 1'b1);
        wait_done(c);
        total++;
        if (tx_done !== 1'b1 || c != FRAME) begin
            bad++;
            $display("FAIL parity_frame_len: tx_done after %0d clks expected %0d", c, FRAME);
        end
        send(8'h03, 1'b1);
        wait_done(c);
    endtask
`endif

    initial begin : main
        total  = 0;
        bad    = 0;
        rx_cnt = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back_burst();
`ifdef RS232_TX_PARITY_EN
        test_parity();
`endif
        repeat (N) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d bytes never seen expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
